// File: rtl/ctrl_sequencer.sv
// Instruction sequencer for the ALU datapath: fetches 9-bit instructions, decodes them
// into ALU/regfile/dmem controls, resolves branches and stops on the halt word.
module ctrl_sequencer #(
  parameter int          PC_W      = 10,
  parameter logic [8:0]  HALT_INSN = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            done,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rd_data,
  output logic [2:0]      alu_cmd,
  output logic [2:0]      typeselect,
  output logic [3:0]      immed,
  input  logic            notequal,
  input  logic            lessthan,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic            rf_wr_en,
  output logic [2:0]      rf_wr_addr,
  output logic            rf_wr_sel,
  output logic            dmem_rd_en,
  output logic            dmem_wr_en,
  output logic [2:0]      lut_idx,
  input  logic [PC_W-1:0] lut_target,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_XOR   = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_MEM   = 3'b010;
  localparam logic [2:0] OP_BNEQ  = 3'b011;
  localparam logic [2:0] OP_HALF  = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_BLT   = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [8:0]      insn;
  logic [2:0]      op, f1, f2;
  logic            taken;

  assign op        = insn[8:6];
  assign f1        = insn[5:3];
  assign f2        = insn[2:0];
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= '0;
      insn  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_DECODE) insn <= imem_rd_data;
    end
  end

  // All controls are decoded combinationally from state, so an async reset
  // drops every strobe in the same instant.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    done       = 1'b0;
    alu_cmd    = OP_NOP;
    typeselect = '0;
    immed      = '0;
    ra_addr    = '0;
    rb_addr    = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_sel  = 1'b0;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;
    lut_idx    = '0;
    taken      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if (imem_rd_data == HALT_INSN) state_next = S_HALT;
        else                           state_next = S_EXEC;
      end
      S_EXEC: begin
        alu_cmd    = op;
        state_next = S_FETCH;
        case (op)
          OP_XOR, OP_AND: begin
            ra_addr    = f1;
            rb_addr    = f2;
            rf_wr_en   = 1'b1;
            rf_wr_addr = f1;
          end
          OP_SHIFT: begin
            typeselect = f1;
            ra_addr    = f2;
            rf_wr_en   = 1'b1;
            rf_wr_addr = f2;
          end
          OP_MEM: begin
            ra_addr = f2;
            rb_addr = 3'd0;
            if (insn[5]) dmem_wr_en = 1'b1;
            else begin
              dmem_rd_en = 1'b1;
              state_next = S_MEM;
            end
          end
          OP_BNEQ: begin
            ra_addr = f1;
            lut_idx = f2;
            taken   = notequal;
          end
          OP_BLT: begin
            ra_addr = f1;
            lut_idx = f2;
            taken   = lessthan;
          end
          OP_HALF: begin
            ra_addr    = {1'b0, insn[5:4]};
            rf_wr_addr = {1'b0, insn[5:4]};
            immed      = insn[3:0];
            rf_wr_en   = 1'b1;
          end
          default: ;
        endcase
        // Loads defer the pc update to MEM; they can never be branches.
        if (state_next == S_FETCH) pc_next = taken ? lut_target : pc + PC_W'(1);
      end
      S_MEM: begin
        rf_wr_en   = 1'b1;
        rf_wr_sel  = 1'b1;
        rf_wr_addr = 3'd0;
        pc_next    = pc + PC_W'(1);
        state_next = S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          done       = 1'b0;
          pc_next    = '0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
